// File: rtl/seq_det_n_pkg.sv
// Shared definitions for the seq_det_n serial sequence detector.
//   state_e : one-hot FSM encoding (IDLE / LOAD / DETECT)
//   ST_W    : width of the state vector
package seq_det_pkg;
  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE   = 3'b001,
    S_LOAD   = 3'b010,
    S_DETECT = 3'b100
  } state_e;
endpackage

// File: rtl/seq_det_n_if.sv
// Bit-stream, control and status bundle for seq_det_n.
//   master : stream source / controller (drives din, din_valid, load, mask,
//            overlap, clr_cnt; observes dout, pat_ready, match_cnt)
//   slave  : the detector itself
interface seq_det_n_if #(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             load;
  logic             mask_we;
  logic [SEQ_W-1:0] mask_in;
  logic             overlap;
  logic             clr_cnt;
  logic             dout;
  logic             pat_ready;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din, din_valid, load, mask_we, mask_in, overlap, clr_cnt,
    input  dout, pat_ready, match_cnt
  );

  modport slave (
    input  din, din_valid, load, mask_we, mask_in, overlap, clr_cnt,
    output dout, pat_ready, match_cnt
  );
endinterface

// File: rtl/seq_shift_cmp.sv
// History shift register, fill counter and masked compare for seq_det_n.
//   clk, rst  : clock, async active-high reset
//   shift_en  : accept din into the history this cycle
//   clr       : empty the history (pattern just armed)
//   din       : serial bit
//   overlap   : 1 = keep fill after a match, 0 = restart the window
//   pat, mask : reference pattern and compare mask (1 = compare bit)
//   match     : combinational, valid in the cycle that shifts the final bit
module seq_shift_cmp #(
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  input  logic             overlap,
  input  logic [SEQ_W-1:0] pat,
  input  logic [SEQ_W-1:0] mask,
  output logic             match
);
  localparam int FW = $clog2(SEQ_W + 1);

  logic [SEQ_W-1:0] hist_q, hist_d, hist_n;
  logic [FW-1:0]    fill_q, fill_d, fill_n;

  always_comb begin
    hist_n = {hist_q[SEQ_W-2:0], din};
    fill_n = (fill_q == FW'(SEQ_W)) ? fill_q : fill_q + 1'b1;
    // Compare against the history including the bit arriving now, so dout
    // can be registered one edge after the final bit is sampled.
    match  = shift_en && (fill_n == FW'(SEQ_W)) && (((hist_n ^ pat) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_n;
      // Non-overlapping: a match consumes the window, SEQ_W fresh bits needed.
      fill_d = (match && !overlap) ? '0 : fill_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_det_n.sv
// Parametrised serial sequence detector (SOF / flag / stuff-pattern watch).
//   clk, rst : clock, async active-high reset
//   bus      : seq_det_n_if slave -- din/din_valid stream, load (serial
//              MSB-first pattern load), mask_we/mask_in, overlap, clr_cnt;
//              outputs dout (1-cycle match pulse), pat_ready, match_cnt
module seq_det_n
  import seq_det_pkg::*;
#(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_det_n_if.slave  bus
);
  localparam int          LDW  = $clog2(SEQ_W);
  localparam logic [LDW-1:0] LAST = LDW'(SEQ_W - 1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] pat_q, pat_d;
  logic [SEQ_W-1:0] mask_q, mask_d;
  logic [LDW-1:0]   ld_cnt_q, ld_cnt_d;
  logic             dout_q, dout_d;
  logic             pat_ready_q, pat_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_en, hist_clr, match;

  seq_shift_cmp #(.SEQ_W(SEQ_W)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (hist_clr),
    .din      (bus.din),
    .overlap  (bus.overlap),
    .pat      (pat_q),
    .mask     (mask_q),
    .match    (match)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    ld_cnt_d    = ld_cnt_q;
    pat_ready_d = pat_ready_q;
    mask_d      = bus.mask_we ? bus.mask_in : mask_q;
    cnt_d       = cnt_q;
    dout_d      = 1'b0;
    shift_en    = 1'b0;
    hist_clr    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (!bus.load) begin
          state_d = S_IDLE;                 // abort: partial pattern discarded
        end else if (bus.din_valid) begin
          pat_d    = {pat_q[SEQ_W-2:0], bus.din};
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST) begin
            state_d     = S_DETECT;
            pat_ready_d = 1'b1;
            hist_clr    = 1'b1;
          end
        end
      end
      S_DETECT: begin
        if (bus.load) begin
          // Reload request: this cycle's din is dropped, not loaded.
          state_d     = S_LOAD;
          pat_ready_d = 1'b0;
          ld_cnt_d    = '0;
        end else begin
          shift_en = bus.din_valid;
          dout_d   = match;
          if (match && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clr_cnt) cnt_d = '0;          // clear beats a coincident match
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      mask_q      <= '1;
      ld_cnt_q    <= '0;
      dout_q      <= 1'b0;
      pat_ready_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      mask_q      <= mask_d;
      ld_cnt_q    <= ld_cnt_d;
      dout_q      <= dout_d;
      pat_ready_q <= pat_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.pat_ready = pat_ready_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_det_n.sv
// Self-checking bench for seq_det_n: vector table, directed corner cases,
// and randomized episodes against a queue-based reference model. Two DUTs
// (CNT_W=8 and CNT_W=2) share the same stimulus.
module tb_seq_det_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       din = 0, din_valid = 0, load = 0, mask_we = 0, overlap = 1, clr_cnt = 0;
  logic [7:0] mask_in = 8'hFF;

  seq_det_n_if #(.SEQ_W(8), .CNT_W(8)) b8 ();
  seq_det_n_if #(.SEQ_W(8), .CNT_W(2)) b2 ();

  assign b8.din = din;         assign b2.din = din;
  assign b8.din_valid = din_valid; assign b2.din_valid = din_valid;
  assign b8.load = load;       assign b2.load = load;
  assign b8.mask_we = mask_we; assign b2.mask_we = mask_we;
  assign b8.mask_in = mask_in; assign b2.mask_in = mask_in;
  assign b8.overlap = overlap; assign b2.overlap = overlap;
  assign b8.clr_cnt = clr_cnt; assign b2.clr_cnt = clr_cnt;

  seq_det_n #(.SEQ_W(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  seq_det_n #(.SEQ_W(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_mode;     // 0 idle, 1 loading, 2 detecting
  logic [7:0] m_pat, m_mask;
  int         m_nload, m_fresh, m_cnt8, m_cnt2;
  bit         m_hist[$];  // last received bits, oldest first
  bit         m_dout, m_rdy;

  function automatic void model_reset();
    m_mode = 0; m_pat = 0; m_mask = 8'hFF; m_nload = 0; m_fresh = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_hist.delete(); m_dout = 0; m_rdy = 0;
  endfunction

  function automatic void model_step();
    bit hit = 0;
    case (m_mode)
      0: if (load) begin m_mode = 1; m_nload = 0; end
      1: if (!load) m_mode = 0;
         else if (din_valid) begin
           m_pat = {m_pat[6:0], din};
           m_nload++;
           if (m_nload == 8) begin
             m_mode = 2; m_rdy = 1; m_hist.delete(); m_fresh = 0;
           end
         end
      default:
         if (load) begin m_mode = 1; m_rdy = 0; m_nload = 0; end
         else if (din_valid) begin
           m_hist.push_back(din);
           if (m_hist.size() > 8) void'(m_hist.pop_front());
           m_fresh++;
           if (m_fresh >= 8) begin
             hit = 1;
             for (int i = 0; i < 8; i++)
               if (m_mask[7-i] && (m_hist[i] != m_pat[7-i])) hit = 0;
           end
           if (hit && !overlap) m_fresh = 0;
         end
    endcase
    m_dout = hit;
    if (clr_cnt) begin m_cnt8 = 0; m_cnt2 = 0; end
    else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (mask_we) m_mask = mask_in;
  endfunction

  // One clock with model tracking; compares both DUTs to the model.
  task automatic tick();
    model_step();
    @(posedge clk); #1;
    chk("dout8", int'(b8.dout), int'(m_dout));
    chk("rdy8", int'(b8.pat_ready), int'(m_rdy));
    chk("cnt8", int'(b8.match_cnt), m_cnt8);
    chk("dout2", int'(b2.dout), int'(m_dout));
    chk("cnt2", int'(b2.match_cnt), m_cnt2);
  endtask

  task automatic do_reset();
    rst = 1; din = 0; din_valid = 0; load = 0; mask_we = 0; clr_cnt = 0;
    overlap = 1; mask_in = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic load_pat(input logic [7:0] p);
    load = 1; din_valid = 0; tick();
    for (int i = 7; i >= 0; i--) begin din_valid = 1; din = p[i]; tick(); end
    load = 0; din_valid = 0;
  endtask

  task automatic send(input logic [31:0] bits, input int n, output int pulses);
    pulses = 0;
    for (int i = n - 1; i >= 0; i--) begin
      din = bits[i]; din_valid = 1; tick();
      pulses += int'(b8.dout);
    end
    din_valid = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ld, v, d;
    bit xd, xr;
    int xc;
  } vec_t;
  vec_t tv[$];

  function automatic void add(bit ld, bit v, bit d, bit xd, bit xr, int xc);
    vec_t e;
    e.ld = ld; e.v = v; e.d = d; e.xd = xd; e.xr = xr; e.xc = xc;
    tv.push_back(e);
  endfunction

  initial begin
    logic [7:0] p;
    logic [8:0] s;
    int pl, pidx, k, ab;

    do_reset();
    chk("rst_dout", int'(b8.dout), 0);
    chk("rst_rdy", int'(b8.pat_ready), 0);
    chk("rst_cnt", int'(b8.match_cnt), 0);

    // Test 1 as a table: load 1011_0010, stream 0,1,0,1,1,0,0,1,0.
    p = 8'b1011_0010;
    s = 9'b0_1011_0010;
    add(1, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) add(1, 1, p[i], 0, (i == 0), 0);
    for (int i = 8; i >= 0; i--) add(0, 1, s[i], (i == 0), 1, (i == 0) ? 1 : 0);
    add(0, 0, 0, 0, 1, 1);        // idle gap: pulse gone, count holds
    add(1, 1, 1, 0, 0, 1);        // reload request drops pat_ready
    add(0, 0, 0, 0, 0, 1);        // load falls: back to idle
    foreach (tv[i]) begin
      load = tv[i].ld; din_valid = tv[i].v; din = tv[i].d;
      model_step();
      @(posedge clk); #1;
      chk($sformatf("tv%0d_dout", i), int'(b8.dout), int'(tv[i].xd));
      chk($sformatf("tv%0d_rdy", i), int'(b8.pat_ready), int'(tv[i].xr));
      chk($sformatf("tv%0d_cnt", i), int'(b8.match_cnt), tv[i].xc);
    end
    load = 0; din_valid = 0;

    // Test 2: overlapping vs non-overlapping on 1010 repeated.
    do_reset(); overlap = 1;
    load_pat(8'hAA); send(32'hAAA, 12, pl);
    chk("ovl_pulses", pl, 3);
    chk("ovl_cnt", int'(b8.match_cnt), 3);
    do_reset(); overlap = 0;
    load_pat(8'hAA); send(32'hAAA, 12, pl);
    chk("novl_pulses", pl, 1);

    // Test 3: masked compare.
    do_reset();
    load_pat(8'hFF);
    mask_we = 1; mask_in = 8'hF0; tick(); mask_we = 0;
    send(32'hF5, 8, pl);
    chk("mask_f0_pulses", pl, 1);
    mask_we = 1; mask_in = 8'hFF; tick(); mask_we = 0;
    send(32'hF5, 8, pl);
    chk("mask_ff_pulses", pl, 0);

    // Test 4: aborted load, then full reload.
    do_reset();
    load = 1; tick();
    for (int i = 7; i >= 3; i--) begin din_valid = 1; din = p[i]; tick(); end
    load = 0; din_valid = 0; tick();
    chk("abort_rdy", int'(b8.pat_ready), 0);
    send(32'hB2, 8, pl);
    chk("abort_pulses", pl, 0);
    load_pat(8'hB2); send(32'hB2, 8, pl);
    chk("reload_pulses", pl, 1);

    // Test 5: valid only every 3rd clock.
    do_reset();
    load_pat(8'hB2);
    pl = 0; pidx = -1;
    for (int i = 0; i < 24; i++) begin
      din_valid = (i % 3 == 0);
      din = din_valid ? p[7 - i/3] : 1'b1;
      tick();
      if (b8.dout) begin pl++; pidx = i; end
    end
    din_valid = 0;
    chk("gap_pulses", pl, 1);
    chk("gap_pulse_at", pidx, 21);

    // Test 6: saturation, clr vs match, async reset between edges.
    do_reset(); overlap = 1;
    load_pat(8'hAA); send(32'hAAAA, 16, pl);
    chk("sat_pulses", pl, 5);
    chk("sat_cnt2", int'(b2.match_cnt), 3);
    chk("sat_cnt8", int'(b8.match_cnt), 5);
    din_valid = 1; din = 1; tick();
    din = 0; clr_cnt = 1; tick(); clr_cnt = 0;
    chk("clr_dout", int'(b8.dout), 1);
    chk("clr_cnt8", int'(b8.match_cnt), 0);
    chk("clr_cnt2", int'(b2.match_cnt), 0);
    din = 1; tick(); din = 0; tick(); din_valid = 0;
    chk("pre_rst_dout", int'(b8.dout), 1);
    #2 rst = 1;
    #1;
    chk("arst_dout", int'(b8.dout), 0);
    chk("arst_rdy", int'(b8.pat_ready), 0);
    chk("arst_cnt", int'(b8.match_cnt), 0);
    do_reset();

    // Randomized episodes: (re)load with gaps and occasional abort, then a
    // stream biased towards the pattern so matches actually occur.
    for (int ep = 0; ep < 30; ep++) begin
      p = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        mask_we = 1; mask_in = 8'($urandom | $urandom); tick(); mask_we = 0;
      end
      ab = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : 8;
      load = 1; din_valid = 0; tick();
      k = 0;
      while (k < 8) begin
        if (k == ab) begin load = 0; din_valid = 0; tick(); break; end
        din_valid = ($urandom_range(3) != 0);
        din = p[7 - k];
        tick();
        if (din_valid) k++;
      end
      load = 0;
      k = 0;
      for (int c = 0; c < 100; c++) begin
        din_valid = ($urandom_range(3) != 0);
        din = ($urandom_range(1) == 0) ? p[7 - (k % 8)] : 1'($urandom);
        if ($urandom_range(15) == 0) overlap = ~overlap;
        clr_cnt = ($urandom_range(31) == 0);
        mask_we = ($urandom_range(39) == 0);
        mask_in = 8'($urandom | $urandom);
        tick();
        if (din_valid) k++;
      end
      clr_cnt = 0; mask_we = 0; din_valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_det_n.md
Name: seq_det_n

Overview:
Parametrised serial sequence detector for the CAN controller datapath, such as SOF/flag/stuff-pattern watch on the recovered bit stream. It is the generalised successor of the fixed 8-bit detector.
- Pattern width is SEQ_W bits, loaded serially MSB-first.
- A per-bit don't-care mask applies during compare.
- Detection is qualified by din_valid.
- Overlapping and non-overlapping modes are supported.
- A saturating match counter is provided.

Parameters:
SEQ_W, 8, pattern/history width in bits; legal range 2..32.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  1  serial bit; used only when din_valid=1.
din_valid  input  1  bit qualifier; when low, all shift/compare state holds.
load  input  1  high = (re)load pattern serially from din.
mask_we  input  1  write enable for mask register.
mask_in  input  SEQ_W  mask value; 1 = compare bit, 0 = don't care.
overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
clr_cnt  input  1  synchronous clear of match_cnt.
dout  output  1  registered one-cycle match pulse.
pat_ready  output  1  high when a complete pattern is held and detection is armed.
match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
Reset (async, rst=1), effective immediately:
- state=IDLE, pat=0, hist=0, fill=0, ld_cnt=0, mask=all ones.
- dout=0, pat_ready=0, match_cnt=0.

FSM is one-hot with states IDLE, LOAD, DETECT.

IDLE:
- load=1 -> LOAD, ld_cnt<=0. Otherwise stay.
- dout=0.

LOAD:
- Each din_valid: pat <= {pat[SEQ_W-2:0], din}; ld_cnt++. The first received bit ends at pat[SEQ_W-1].
- On the valid bit with ld_cnt==SEQ_W-1 -> DETECT; pat_ready<=1, hist<=0, fill<=0.
- load falls before completion -> IDLE (abort). pat_ready stays 0; the partial pat is invalid.
- din_valid=0 while load=1: hold.

DETECT:
- Each din_valid: hist_n = {hist[SEQ_W-2:0], din}; fill saturates at SEQ_W.
- match = (fill_n==SEQ_W) && (((hist_n ^ pat) & mask)==0).
- dout <= match, so it is high for exactly the one cycle after the edge that sampled the last pattern bit.
- On match, match_cnt increments and saturates at 2^CNT_W-1.
- overlap=1: hist/fill retained after a match.
- overlap=0: fill<=0 on match, so the next match needs SEQ_W fresh bits.
- load=1 -> LOAD. The din bit sampled in that cycle is discarded. pat_ready<=0, dout<=0, ld_cnt<=0.

General rules:
- Latency: 1 clk from the sampling edge of the final bit to dout.
- din_valid=0 in any state: no shift, no match, dout<=0.
- mask_we is honoured in any state and takes effect from the next compare. Mask all-zero with overlap=1 matches on every valid bit once fill==SEQ_W.
- clr_cnt and match in the same cycle: clr wins, match_cnt<=0. dout still pulses.
- overlap may change at any time and is sampled per match.
- rst mid-LOAD or mid-DETECT: all state is lost and the pattern must be reloaded.
- match_cnt holds while not in DETECT.

Decomposition:
Package seq_det_pkg:
- one-hot state constants S_IDLE=3'b001, S_LOAD=3'b010, S_DETECT=3'b100.
- state type width constant.

Sub-module seq_shift_cmp (SEQ_W):
- history shift register, fill counter, masked compare.
- produces a combinational match.
- top level holds the FSM, pattern/mask registers and counter.

Test Plan:
1. SEQ_W=8, load pattern 8'b1011_0010, then stream 0,1,0,1,1,0,0,1,0 (din_valid=1) -> dout pulses once, 1 clk after bit 9; match_cnt=1; pat_ready=1 from the cycle after the 8th load bit.
2. Pattern 8'b1010_1010, overlap=1, stream 1010 repeated 12 bits -> dout on bits 8, 10, 12 (match_cnt=3). With overlap=0 -> dout on bit 8 only.
3. Pattern 8'hFF, mask_in=8'b1111_0000, stream 8'b1111_0101 -> dout=1. Same stream with mask 8'hFF -> no dout.
4. Load aborted after 5 bits (load drops) -> state IDLE, pat_ready=0, no dout on subsequent matching stream. Full reload then detects.
5. din_valid gapped (valid every 3rd clk) with a matching stream -> single dout after the 8th valid bit; no dout during gaps.
6. CNT_W=2, 5 matches -> match_cnt sticks at 3. clr_cnt coincident with a match -> match_cnt=0 and dout=1. Async rst asserted mid-DETECT between edges -> outputs 0 immediately.
